// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory controller slice: word, RAM handshake state,
// controller FSM state and the word returned on a failed access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } memctl_state_t;

  localparam word_t MEMCTL_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memctl_arb.sv
// Two-requester arbiter for the memory controller (icache vs dcache).
// MEMCTL_RR_EN selects round-robin; otherwise dcache has fixed priority.
module memctl_arb (
`ifdef MEMCTL_RR_EN
  input  logic clk_i,
  input  logic rst_i,
  input  logic idone_i,
  input  logic ddone_i,
`endif
  input  logic ireq_i,
  input  logic dreq_i,
  output logic igrant_o,
  output logic dgrant_o
);

`ifdef MEMCTL_RR_EN
  // Favoured port moves to the other requester after every completed access.
  logic fav_d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fav_d_q <= 1'b1;
    end else if (idone_i) begin
      fav_d_q <= 1'b1;
    end else if (ddone_i) begin
      fav_d_q <= 1'b0;
    end
  end

  always_comb begin
    dgrant_o = dreq_i & (~ireq_i | fav_d_q);
    igrant_o = ireq_i & (~dreq_i | ~fav_d_q);
  end
`else
  always_comb begin
    dgrant_o = dreq_i;
    igrant_o = ireq_i & ~dreq_i;
  end
`endif

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder arbitrating icache/dcache requests onto one RAM port.
// Build option: MEMCTL_RR_EN enables round-robin arbitration (default: dcache priority).
module cache_mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              memerr
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [WORD_W-1:0] ERR_WORD = WORD_W'(MEMCTL_ERR_WORD);

  memctl_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             memerr_q;

  logic dreq, d_rd, igrant, dgrant;
  logic req_live, timeout_hit, done, err_hit, idone, ddone;

  memctl_arb u_arb (
`ifdef MEMCTL_RR_EN
    .clk_i    (CLK),
    .rst_i    (RST),
    .idone_i  (idone),
    .ddone_i  (ddone),
`endif
    .ireq_i   (iREN),
    .dreq_i   (dreq),
    .igrant_o (igrant),
    .dgrant_o (dgrant)
  );

  always_comb begin
    dreq        = dREN | dWEN;
    d_rd        = dREN & ~dWEN;
    req_live    = ((state_q == GRANT_I) & iREN) | ((state_q == GRANT_D) & dreq);
    timeout_hit = (cnt_q == CNT_MAX);
    // A live request that reaches ACCESS completes cleanly even if the counter expired.
    done        = req_live & ((ramstate == ACCESS) | (ramstate == ERROR) | timeout_hit);
    err_hit     = done & (ramstate != ACCESS);
    idone       = done & (state_q == GRANT_I);
    ddone       = done & (state_q == GRANT_D);
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      GRANT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (idone) begin
          iwait = 1'b0;
          iload = err_hit ? ERR_WORD : ramload;
        end
      end
      GRANT_D: begin
        ramREN   = d_rd;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ddone) begin
          dwait = 1'b0;
          dload = err_hit ? ERR_WORD : (d_rd ? ramload : '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      memerr_q <= 1'b0;
    end else begin
      memerr_q <= memerr_q | err_hit;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (dgrant) begin
            state_q <= GRANT_D;
          end else if (igrant) begin
            state_q <= GRANT_I;
          end
        end
        GRANT_I, GRANT_D: begin
          if (!req_live || done) begin
            state_q <= IDLE;
          end
          if (!timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memerr = memerr_q;

endmodule
